prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Parametrised program sequencer for the 9-bit-ISA processor: owns the program counter, a writable jump-target table, and a req/done four-phase run handshake. It replaces the free-running PC, the hardwired PC_LUT taps, and the `prog_ctr == 128` done compare. The top level feeds it decoder outputs (halt, branch, stall) and drives the instruction ROM from `prog_ctr`.

## Interface
- D, 12: program counter width
- LUT_N, 8: jump-target table entries (power of 2, ≥2); index width LW = $clog2(LUT_N)
- REL_W, 6: signed relative-branch offset width (≤ D)
- END_ADDR, 128: PC value that ends a run when reached without a halt
- CW, 16: cycle counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces the reset state immediately
- req  in  1  run request (level, four-phase)
- done  out  1  run complete; reset 0
- busy  out  1  high in RUN; reset 0
- stall  in  1  hold PC this cycle
- halt  in  1  decoded halt instruction at current PC
- abs_br  in  1  take absolute jump to lut[br_idx]
- rel_br  in  1  take relative jump by rel_off
- br_idx  in  LW  jump-table index
- rel_off  in  REL_W  two's-complement offset
- lut_we  in  1  jump-table write enable
- lut_widx  in  LW  write index
- lut_wdata  in  D  write data
- prog_ctr  out  D  current PC; reset 0
- cycle_cnt  out  CW  cycles spent in RUN for the last/current run; reset 0

## Operation
- FSM states: IDLE, RUN, DONE; reset → IDLE.
- IDLE: PC held at 0. When req=1 → RUN next cycle; PC=0, cycle_cnt cleared to 0 on the same edge.
- RUN (busy=1), per cycle, priority order:
  1. halt=1 → DONE; PC holds.
  2. stall=1 → PC holds; branches ignored.
  3. abs_br=1 → PC ← lut[br_idx].
  4. rel_br=1 → PC ← PC + sign_ext(rel_off), modulo 2^D.
  5. else PC ← PC+1, modulo 2^D.
- If the next PC computed in RUN equals END_ADDR → DONE, with PC = END_ADDR.
- abs_br and rel_br both high: abs_br wins.
- cycle_cnt increments on every RUN cycle, including stalled cycles and the exiting cycle; saturates at 2^CW−1.
- DONE: done=1, PC and cycle_cnt held. When req=0 → IDLE. done drops on that same edge.
- req dropped during RUN is ignored; the run completes.
- Jump table: LUT_N×D registers, reset to 0. Writes are accepted in any state. The read is combinational from current contents, so a same-cycle write to the jumped-to index yields the old value.
- Inputs other than req, lut_* are ignored outside RUN.

## Timing
- All outputs are registered, except busy and done, which are decoded from the state register. None are combinational from inputs.
- A req edge seen in IDLE makes busy=1 on the following cycle. The first instruction fetched is at PC 0.
- Branch/halt decision latency: zero cycles. The new PC appears after the edge on which the inputs were sampled.
- Minimum run: req → RUN (1 cycle) → halt at PC 0 → DONE. cycle_cnt=1.
- Reset mid-run: state=IDLE, PC=0, cycle_cnt=0, LUT cleared, done=busy=0, all asynchronously.

## Structure
- Package `seq_pkg`: state enum (IDLE, RUN, DONE) and default parameter constants.
- One sub-module: `jump_lut` (write port, one combinational read port, async reset). The FSM, PC, and counter stay in `prog_sequencer`.

## Test plan
- Straight-line run: D=12, END_ADDR=128, req=1, no branches → PC 0..127 then 128. done=1 with cycle_cnt=128; req=0 → IDLE, done=0.
- Absolute jump: write lut[3]=0x040, run, assert abs_br with br_idx=3 at PC 5 → PC=0x040 next. Same-cycle lut_we to index 3 with 0x050 → PC still 0x040.
- Relative branches: rel_off=−3 at PC 10 → 7. rel_off=+31 at PC 0xFF0 with D=12 and END_ADDR beyond reach → PC wraps to 0x00F.
- Priority: halt+abs_br same cycle → DONE, PC unchanged. stall+rel_br → PC held, cycle_cnt still increments.
- Saturation: CW=4, run 20 cycles → cycle_cnt sticks at 15.
- Reset mid-run at PC 50, then req held high → IDLE, all outputs 0 immediately, LUT reads 0. After reset release, a new run starts at PC 0.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: run-state encoding and
// default parameter values used by the sequencer and its jump table.
package seq_pkg;

    localparam int D_DEF        = 12;
    localparam int LUT_N_DEF    = 8;
    localparam int REL_W_DEF    = 6;
    localparam int END_ADDR_DEF = 128;
    localparam int CW_DEF       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Plain-vector forms of the states for legacy tools that dislike enum regs.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

endpackage

// File: rtl/prog_sequencer_if.sv
// Run handshake, decoder controls, jump-table write port and status outputs
// of the program sequencer, bundled for the processor top level.
interface prog_sequencer_if #(
    parameter int D     = 12,
    parameter int LW    = 3,
    parameter int REL_W = 6,
    parameter int CW    = 16
);
    logic                    req;
    logic                    done;
    logic                    busy;
    logic                    stall;
    logic                    halt;
    logic                    abs_br;
    logic                    rel_br;
    logic [LW-1:0]           br_idx;
    logic signed [REL_W-1:0] rel_off;
    logic                    lut_we;
    logic [LW-1:0]           lut_widx;
    logic [D-1:0]            lut_wdata;
    logic [D-1:0]            prog_ctr;
    logic [CW-1:0]           cycle_cnt;

    modport master (
        output req, stall, halt, abs_br, rel_br, br_idx, rel_off,
               lut_we, lut_widx, lut_wdata,
        input  done, busy, prog_ctr, cycle_cnt
    );

    modport slave (
        input  req, stall, halt, abs_br, rel_br, br_idx, rel_off,
               lut_we, lut_widx, lut_wdata,
        output done, busy, prog_ctr, cycle_cnt
    );
endinterface

// File: rtl/prog_sequencer_jump_lut.sv
// Writable jump-target table: one synchronous write port and one
// combinational read port, so a same-cycle write is not seen by the read.
module jump_lut #(
    parameter  int LUT_N = 8,
    parameter  int D     = 12,
    localparam int LW    = $clog2(LUT_N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [LW-1:0] widx_i,
    input  logic [D-1:0]  wdata_i,
    input  logic [LW-1:0] ridx_i,
    output logic [D-1:0]  rdata_o
);

    logic [D-1:0] mem_q [LUT_N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: run FSM (IDLE/RUN/DONE), program counter with
// halt/stall/absolute/relative control, and a saturating run-cycle counter.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int D        = D_DEF,
    parameter int LUT_N    = LUT_N_DEF,
    parameter int REL_W    = REL_W_DEF,
    parameter int END_ADDR = END_ADDR_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    prog_sequencer_if.slave  bus
);

    // Compared at 32 bits so an END_ADDR outside the PC range never matches.
    localparam logic [31:0] END_U = 32'(END_ADDR);

    logic [1:0]              state_q, state_d;
    logic [D-1:0]            pc_q, pc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [D-1:0]            lut_rdata;
    logic [D-1:0]            pc_run;
    logic signed [REL_W-1:0] rel_off;
    logic signed [D-1:0]     off_ext;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    jump_lut #(.LUT_N(LUT_N), .D(D)) u_lut (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bus.lut_we),
        .widx_i  (bus.lut_widx),
        .wdata_i (bus.lut_wdata),
        .ridx_i  (bus.br_idx),
        .rdata_o (lut_rdata)
    );

    assign rel_off = bus.rel_off;
    assign off_ext = D'(rel_off);

    always_comb begin
        if (bus.stall) begin
            pc_run = pc_q;
        end else if (bus.abs_br) begin
            pc_run = lut_rdata;
        end else if (bus.rel_br) begin
            pc_run = pc_q + off_ext;
        end else begin
            pc_run = pc_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (bus.req) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (bus.halt) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d = pc_run;
                    if (32'(pc_run) == END_U) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.req) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.prog_ctr  = pc_q;
    assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed vector table, hand-written corner
// sequences and a randomized run compared against a behavioural model.
module tb_prog_sequencer;

    typedef struct {
        bit req, stall, halt, abs_br, rel_br, we;
        int idx, off, widx, wdata;
    } in_t;

    typedef struct {
        in_t in;
        int  pc;
        bit  dn, bz;
        int  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    prog_sequencer_if #(.D(12), .LW(3), .REL_W(6), .CW(16)) bus_a ();
    prog_sequencer_if #(.D(12), .LW(3), .REL_W(6), .CW(4))  bus_b ();

    prog_sequencer #(.D(12), .LUT_N(8), .REL_W(6), .END_ADDR(128), .CW(16)) u_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    prog_sequencer #(.D(12), .LUT_N(8), .REL_W(6), .END_ADDR(4096), .CW(4)) u_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of unit A: phase 0=idle, 1=running, 2=finished.
    int m_phase, m_pc, m_cnt;
    int m_lut[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic in_t mk(bit req, bit stall, bit halt, bit ab, bit rb,
                               int idx, int off, bit we, int widx, int wdata);
        in_t v;
        v.req = req; v.stall = stall; v.halt = halt; v.abs_br = ab; v.rel_br = rb;
        v.idx = idx; v.off = off; v.we = we; v.widx = widx; v.wdata = wdata;
        return v;
    endfunction

    function automatic in_t plain(bit req);
        return mk(req, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 0; m_cnt = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
    endtask

    task automatic model_a(input in_t v);
        int rd;
        rd = m_lut[v.idx];
        case (m_phase)
            0: begin
                m_pc = 0;
                if (v.req) begin m_phase = 1; m_cnt = 0; end
            end
            1: begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (v.halt) m_phase = 2;
                else begin
                    if (v.stall)       m_pc = m_pc;
                    else if (v.abs_br) m_pc = rd;
                    else if (v.rel_br) m_pc = (m_pc + v.off + 4096) % 4096;
                    else               m_pc = (m_pc + 1) % 4096;
                    if (m_pc == 128) m_phase = 2;
                end
            end
            default: if (!v.req) begin m_phase = 0; m_pc = 0; end
        endcase
        if (v.we) m_lut[v.widx] = v.wdata;
    endtask

    task automatic drive_a(input in_t v);
        bus_a.req = v.req; bus_a.stall = v.stall; bus_a.halt = v.halt;
        bus_a.abs_br = v.abs_br; bus_a.rel_br = v.rel_br;
        bus_a.br_idx = 3'(v.idx); bus_a.rel_off = 6'(v.off);
        bus_a.lut_we = v.we; bus_a.lut_widx = 3'(v.widx); bus_a.lut_wdata = 12'(v.wdata);
    endtask

    task automatic drive_b(input in_t v);
        bus_b.req = v.req; bus_b.stall = v.stall; bus_b.halt = v.halt;
        bus_b.abs_br = v.abs_br; bus_b.rel_br = v.rel_br;
        bus_b.br_idx = 3'(v.idx); bus_b.rel_off = 6'(v.off);
        bus_b.lut_we = v.we; bus_b.lut_widx = 3'(v.widx); bus_b.lut_wdata = 12'(v.wdata);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},   32'(bus_a.prog_ctr),  m_pc);
        chk({tag, ".done"}, 32'(bus_a.done),      (m_phase == 2) ? 1 : 0);
        chk({tag, ".busy"}, 32'(bus_a.busy),      (m_phase == 1) ? 1 : 0);
        chk({tag, ".cnt"},  32'(bus_a.cycle_cnt), m_cnt);
    endtask

    task automatic step_a(input in_t v, input string tag);
        drive_a(v);
        @(posedge clk);
        model_a(v);
        #1;
        check_model(tag);
    endtask

    task automatic step_b(input in_t v);
        drive_b(v);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{mk(0,0,0,0,0, 0, 0, 1,3,12'h040), 12'h000, 0, 0, 0};
        tbl[1]  = '{plain(1),                          12'h000, 0, 1, 0};
        tbl[2]  = '{plain(1),                          12'h001, 0, 1, 1};
        tbl[3]  = '{plain(1),                          12'h002, 0, 1, 2};
        tbl[4]  = '{plain(1),                          12'h003, 0, 1, 3};
        tbl[5]  = '{plain(1),                          12'h004, 0, 1, 4};
        tbl[6]  = '{plain(1),                          12'h005, 0, 1, 5};
        tbl[7]  = '{mk(1,0,0,1,0, 3, 0, 1,3,12'h050), 12'h040, 0, 1, 6};
        tbl[8]  = '{mk(1,0,0,1,0, 3, 0, 0,0,0),       12'h050, 0, 1, 7};
        tbl[9]  = '{mk(1,0,0,0,1, 0,-3, 0,0,0),       12'h04D, 0, 1, 8};
        tbl[10] = '{mk(1,1,0,0,1, 0, 5, 0,0,0),       12'h04D, 0, 1, 9};
        tbl[11] = '{mk(1,0,0,1,1, 3, 7, 0,0,0),       12'h050, 0, 1, 10};
        tbl[12] = '{mk(1,0,1,1,0, 0, 0, 0,0,0),       12'h050, 1, 0, 11};
        tbl[13] = '{plain(1),                          12'h050, 1, 0, 11};
        tbl[14] = '{plain(0),                          12'h000, 0, 0, 11};

        model_reset();
        drive_a(plain(0));
        drive_b(plain(0));
        #12;
        chk("rst_a.pc",   32'(bus_a.prog_ctr), 0);
        chk("rst_a.done", 32'(bus_a.done), 0);
        chk("rst_a.busy", 32'(bus_a.busy), 0);
        chk("rst_a.cnt",  32'(bus_a.cycle_cnt), 0);
        chk("rst_b.pc",   32'(bus_b.prog_ctr), 0);
        #10 reset = 1'b0;

        // Directed table: jump, same-cycle write, priority cases.
        for (int i = 0; i < 15; i++) begin
            drive_a(tbl[i].in);
            @(posedge clk);
            model_a(tbl[i].in);
            #1;
            chk($sformatf("tbl%0d.pc", i),   32'(bus_a.prog_ctr),  tbl[i].pc);
            chk($sformatf("tbl%0d.done", i), 32'(bus_a.done),      32'(tbl[i].dn));
            chk($sformatf("tbl%0d.busy", i), 32'(bus_a.busy),      32'(tbl[i].bz));
            chk($sformatf("tbl%0d.cnt", i),  32'(bus_a.cycle_cnt), tbl[i].cnt);
        end

        // Straight-line run to END_ADDR.
        step_a(plain(1), "line_start");
        for (int i = 0; i < 128; i++) step_a(plain(1), "line");
        chk("line.end_pc",   32'(bus_a.prog_ctr), 128);
        chk("line.end_cnt",  32'(bus_a.cycle_cnt), 128);
        chk("line.end_done", 32'(bus_a.done), 1);
        step_a(plain(0), "line_release");
        chk("line.idle_done", 32'(bus_a.done), 0);

        // Backward relative branch from PC 10.
        step_a(plain(1), "rel_start");
        for (int i = 0; i < 10; i++) step_a(plain(1), "rel_walk");
        step_a(mk(1,0,0,0,1, 0,-3, 0,0,0), "rel_back");
        chk("rel.back_pc", 32'(bus_a.prog_ctr), 7);
        step_a(mk(1,0,1,0,0, 0,0, 0,0,0), "rel_halt");
        step_a(plain(0), "rel_release");

        // Minimum run: halt at PC 0.
        step_a(plain(1), "min_start");
        step_a(mk(1,0,1,0,0, 0,0, 0,0,0), "min_halt");
        chk("min.cnt", 32'(bus_a.cycle_cnt), 1);
        chk("min.pc",  32'(bus_a.prog_ctr), 0);
        step_a(plain(0), "min_release");

        // Unit B: cycle counter saturation with CW=4.
        step_b(plain(1));
        chk("sat.busy", 32'(bus_b.busy), 1);
        for (int i = 1; i <= 20; i++) begin
            step_b(plain(1));
            chk($sformatf("sat%0d.cnt", i), 32'(bus_b.cycle_cnt), (i < 15) ? i : 15);
        end
        chk("sat.pc", 32'(bus_b.prog_ctr), 20);
        step_b(mk(1,0,1,0,0, 0,0, 0,0,0));
        chk("sat.done", 32'(bus_b.done), 1);
        chk("sat.final_cnt", 32'(bus_b.cycle_cnt), 15);
        step_b(plain(0));

        // Unit B: relative branch wrapping modulo 2^12.
        step_b(mk(0,0,0,0,0, 0,0, 1,2,12'hFF0));
        step_b(plain(1));
        step_b(mk(1,0,0,1,0, 2,0, 0,0,0));
        chk("wrap.jump_pc", 32'(bus_b.prog_ctr), 12'hFF0);
        step_b(mk(1,0,0,0,1, 0,31, 0,0,0));
        chk("wrap.pc",   32'(bus_b.prog_ctr), 12'h00F);
        chk("wrap.busy", 32'(bus_b.busy), 1);
        step_b(mk(1,0,1,0,0, 0,0, 0,0,0));
        step_b(plain(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_t v;
            v.req    = ($urandom_range(0, 7) != 0);
            v.halt   = ($urandom_range(0, 39) == 0);
            v.stall  = ($urandom_range(0, 4) == 0);
            v.abs_br = ($urandom_range(0, 7) == 0);
            v.rel_br = ($urandom_range(0, 3) == 0);
            v.idx    = int'($urandom_range(0, 7));
            v.off    = int'($urandom_range(0, 63)) - 32;
            v.we     = ($urandom_range(0, 3) == 0);
            v.widx   = int'($urandom_range(0, 7));
            v.wdata  = int'($urandom_range(0, 160));
            step_a(v, $sformatf("rnd%0d", i));
        end
        step_a(plain(0), "rnd_drain");
        step_a(plain(0), "rnd_drain2");

        // Reset in the middle of a run at PC 50, req kept high.
        step_a(mk(0,0,0,0,0, 0,0, 1,3,12'h050), "mid_lut");
        step_a(plain(1), "mid_start");
        for (int i = 0; i < 50; i++) step_a(plain(1), "mid_walk");
        chk("mid.pc50", 32'(bus_a.prog_ctr), 50);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model("mid_async");
        @(posedge clk);
        #1;
        check_model("mid_held");
        #2 reset = 1'b0;
        step_a(plain(1), "post_start");
        chk("post.start_pc", 32'(bus_a.prog_ctr), 0);
        step_a(mk(1,0,0,1,0, 3,0, 0,0,0), "post_lut");
        chk("post.lut_cleared", 32'(bus_a.prog_ctr), 0);
        step_a(plain(1), "post_step");
        chk("post.pc1", 32'(bus_a.prog_ctr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
